sw_alloc_wh: RTL and testbench

SW_ALLOC_WH -- requirements
Module: sw_alloc_wh

---
 rtl/sw_alloc_wh_pkg.sv | 28 ++
 rtl/sw_alloc_wh_rr_arb.sv | 46 ++++
 rtl/sw_alloc_wh.sv | 184 ++++++++++++++++++
 tb/tb_sw_alloc_wh.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_alloc_wh_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_pkg
// Purpose  : Shared NoC router constants. Holds the port count, the port index
//            width, the port index map and the switch-allocator FSM state
//            encoding. The router, the RCU and the switch allocator all use it.
// Revision : 1.0 - initial release
// ============================================================================
package noc_pkg;

   localparam int NPORT = 7;
   localparam int PW    = 3;

   // Port index map
   localparam logic [PW-1:0] P_E    = 3'd0;
   localparam logic [PW-1:0] P_W    = 3'd1;
   localparam logic [PW-1:0] P_N    = 3'd2;
   localparam logic [PW-1:0] P_S    = 3'd3;
   localparam logic [PW-1:0] P_PE   = 3'd4;
   localparam logic [PW-1:0] P_UP   = 3'd5;
   localparam logic [PW-1:0] P_DOWN = 3'd6;

   // Per-output allocator FSM encoding
   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] LOCKED = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sw_alloc_wh_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb
// Purpose  : N-way round-robin arbiter. The search starts at i_ptr and wraps
//            modulo N. The first requester found gets a one-hot grant, and its
//            index is driven on o_idx. Purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb
   import noc_pkg::*;
#(
   parameter int N_REQ = NPORT,
   parameter int IDX_W = PW
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   // Rotating priority search: the first requester at or after i_ptr wins
   always_comb begin
      int               w_pos;
      logic [IDX_W-1:0] w_jdx;
      w_pos = 0;
      w_jdx = '0;
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         w_pos = int'(i_ptr) + k;
         if (w_pos >= N_REQ) begin
            w_pos = w_pos - N_REQ;
         end
         w_jdx = IDX_W'(w_pos);
         if (!o_any && i_req[w_jdx]) begin
            o_any        = 1'b1;
            o_gnt[w_jdx] = 1'b1;
            o_idx        = w_jdx;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/sw_alloc_wh.sv
`default_nettype none
// ============================================================================
// Module   : sw_alloc_wh
// Purpose  : Wormhole switch allocator. Each output has its own round-robin
//            arbiter and an IDLE/LOCKED FSM. The FSM holds the output for one
//            packet from its head flit to its tail flit. Grants are
//            zero-latency: rd_en, sel and out_vld are produced in the same
//            cycle as the request.
// Options  : `define SA_LOCK_WDOG_EN adds a per-output stall watchdog. The
//            watchdog forcibly releases a lock that has made no progress for
//            WDOG_CYC cycles.
// Revision : 1.0 - initial release
// ============================================================================
module sw_alloc_wh #(
   parameter int NPORT    = noc_pkg::NPORT,
   parameter int PW       = noc_pkg::PW,
   parameter int WDOG_CYC = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NPORT-1:0]    req_vld,
   input  logic [NPORT*PW-1:0] req_port,
   input  logic [NPORT-1:0]    req_tail,
   input  logic [NPORT-1:0]    out_rdy,
   output logic [NPORT-1:0]    rd_en,
   output logic [NPORT*PW-1:0] sel,
   output logic [NPORT-1:0]    out_vld,
   output logic [NPORT-1:0]    lock,
   output logic [NPORT-1:0]    wdog_err
);
   import noc_pkg::*;

   // The stall counter is 8 bits wide, so the limit must fit in it
   if (WDOG_CYC < 1 || WDOG_CYC > 255) begin : g_bad_wdog_cyc
      $error("sw_alloc_wh: WDOG_CYC must be in 1..255");
   end

   // Next round-robin start position after index v, wrapping at NPORT
   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] v);
      if (int'(v) >= NPORT - 1) begin
         return '0;
      end
      return v + PW'(1);
   endfunction

   // Per-output input grants, flattened as output o -> bits [o*NPORT +: NPORT]
   logic [NPORT*NPORT-1:0] w_gnt_flat;

   for (genvar o = 0; o < NPORT; o++) begin : g_out
      logic [0:0]       r_state, w_state_nxt;
      logic [PW-1:0]    r_owner, w_owner_nxt;
      logic [PW-1:0]    r_ptr, w_ptr_nxt;
      logic [NPORT-1:0] w_elig, w_arb_gnt, w_gnt;
      logic [PW-1:0]    w_arb_idx, w_sel;
      logic             w_arb_any, w_xfer, w_tail, w_release;

      // Eligible inputs: routed here, not a U-turn. Index 7 never matches o.
      always_comb begin
         w_elig = '0;
         for (int i = 0; i < NPORT; i++) begin
            w_elig[i] = req_vld[i] && (req_port[i*PW +: PW] == PW'(o)) && (i != o);
         end
      end

      rr_arb #(
         .N_REQ (NPORT),
         .IDX_W (PW)
      ) u_arb (
         .i_req (w_elig),
         .i_ptr (r_ptr),
         .o_gnt (w_arb_gnt),
         .o_idx (w_arb_idx),
         .o_any (w_arb_any)
      );

      // Output decode: the IDLE winner or the LOCKED owner drives the mux
      always_comb begin
         w_xfer = 1'b0;
         w_tail = 1'b0;
         w_sel  = '0;
         w_gnt  = '0;
         if (r_state == IDLE) begin
            if (w_arb_any && out_rdy[o]) begin
               w_xfer = 1'b1;
               w_sel  = w_arb_idx;
               w_gnt  = w_arb_gnt;
               w_tail = req_tail[w_arb_idx];
            end
         end else begin
            w_sel = r_owner;
            if (req_vld[r_owner] && out_rdy[o]) begin
               w_xfer         = 1'b1;
               w_gnt[r_owner] = 1'b1;
               w_tail         = req_tail[r_owner];
            end
         end
      end

      // Next state: lock on a head flit, release on a tail flit or the watchdog
      always_comb begin
         w_state_nxt = r_state;
         w_owner_nxt = r_owner;
         w_ptr_nxt   = r_ptr;
         case (r_state)
            IDLE: begin
               if (w_xfer) begin
                  if (w_tail) begin
                     w_ptr_nxt = f_inc(w_arb_idx);
                  end else begin
                     w_state_nxt = LOCKED;
                     w_owner_nxt = w_arb_idx;
                  end
               end
            end
            default: begin
               if ((w_xfer && w_tail) || w_release) begin
                  w_state_nxt = IDLE;
                  w_ptr_nxt   = f_inc(r_owner);
               end
            end
         endcase
      end

      // State, owner and pointer registers
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
         end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
         end
      end

`ifdef SA_LOCK_WDOG_EN
      localparam logic [7:0] c_wdog_lim = 8'(WDOG_CYC - 1);
      logic [7:0] r_stall;
      logic       r_err;

      // The limit is reached on the WDOG_CYC-th consecutive stalled LOCKED cycle
      assign w_release = (r_state == LOCKED) && !w_xfer && (r_stall == c_wdog_lim);

      // Stall counter and a one-cycle error flag raised with the forced release
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_stall <= '0;
            r_err   <= 1'b0;
         end else begin
            r_err <= w_release;
            if ((r_state == IDLE) || w_xfer || w_release) begin
               r_stall <= '0;
            end else begin
               r_stall <= r_stall + 8'd1;
            end
         end
      end

      assign wdog_err[o] = rst & r_err;
`else
      assign w_release   = 1'b0;
      assign wdog_err[o] = 1'b0;
`endif

      assign out_vld[o]                   = rst & w_xfer;
      assign lock[o]                      = rst & (r_state == LOCKED);
      assign sel[o*PW +: PW]              = rst ? w_sel : '0;
      assign w_gnt_flat[o*NPORT +: NPORT] = w_gnt;
   end

   // An input pops when the output it routes to grants it
   always_comb begin
      rd_en = '0;
      for (int o = 0; o < NPORT; o++) begin
         rd_en = rd_en | w_gnt_flat[o*NPORT +: NPORT];
      end
      if (!rst) begin
         rd_en = '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sw_alloc_wh.sv
`default_nettype none
// ============================================================================
// Module   : tb_sw_alloc_wh
// Purpose  : Self-checking bench for sw_alloc_wh. It applies a table of
//            vectors, runs directed wormhole sequences, and then applies
//            random traffic. A per-output reference model checks every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sw_alloc_wh;

   localparam int N    = 7;
   localparam int PW   = 3;
   localparam int WDOG = 255;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_vld, req_tail, out_rdy;
   logic [N*PW-1:0] req_port;
   logic [N-1:0]    rd_en, out_vld, lock, wdog_err;
   logic [N*PW-1:0] sel;

   int tests = 0;
   int fails = 0;

   sw_alloc_wh #(
      .NPORT    (N),
      .PW       (PW),
      .WDOG_CYC (WDOG)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_vld  (req_vld),
      .req_port (req_port),
      .req_tail (req_tail),
      .out_rdy  (out_rdy),
      .rd_en    (rd_en),
      .sel      (sel),
      .out_vld  (out_vld),
      .lock     (lock),
      .wdog_err (wdog_err)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   bit              m_lock  [N];
   int              m_owner [N];
   int              m_ptr   [N];
   int              m_stall [N];
   bit              m_err   [N];
   bit              xf      [N];
   int              who     [N];
   logic [N-1:0]    e_rd, e_ov, e_lock, e_err;
   logic [N*PW-1:0] e_sel;

   function automatic int port_of(int i);
      return int'(req_port[i*PW +: PW]);
   endfunction

   function automatic logic [N*PW-1:0] pp(int e, int w, int n, int s, int pe, int up, int dn);
      int              a [N];
      logic [N*PW-1:0] r;
      a = '{e, w, n, s, pe, up, dn};
      r = '0;
      for (int i = 0; i < N; i++) r[i*PW +: PW] = PW'(a[i]);
      return r;
   endfunction

   task automatic model_reset();
      for (int o = 0; o < N; o++) begin
         m_lock[o] = 0; m_owner[o] = 0; m_ptr[o] = 0; m_stall[o] = 0; m_err[o] = 0;
      end
   endtask

   task automatic model_eval();
      e_rd = '0; e_ov = '0; e_lock = '0; e_err = '0; e_sel = '0;
      for (int o = 0; o < N; o++) begin
         xf[o] = 0; who[o] = -1;
      end
      if (rst) begin
         for (int o = 0; o < N; o++) begin
            int win;
            win = -1;
            e_lock[o] = m_lock[o];
            e_err[o]  = m_err[o];
            if (!m_lock[o]) begin
               for (int k = 0; k < N; k++) begin
                  int i;
                  i = (m_ptr[o] + k) % N;
                  if (win < 0 && req_vld[i] && port_of(i) == o && i != o) win = i;
               end
               if (win >= 0 && out_rdy[o]) begin xf[o] = 1; who[o] = win; end
            end else begin
               e_sel[o*PW +: PW] = PW'(m_owner[o]);
               if (req_vld[m_owner[o]] && out_rdy[o]) begin xf[o] = 1; who[o] = m_owner[o]; end
            end
            if (xf[o]) begin
               e_ov[o] = 1'b1;
               e_rd[who[o]] = 1'b1;
               e_sel[o*PW +: PW] = PW'(who[o]);
            end
         end
      end
   endtask

   task automatic model_step();
      for (int o = 0; o < N; o++) begin
         bit en;
         en = 0;
         if (!rst) begin
            m_lock[o] = 0; m_owner[o] = 0; m_ptr[o] = 0; m_stall[o] = 0;
         end else if (!m_lock[o]) begin
            m_stall[o] = 0;
            if (xf[o]) begin
               if (req_tail[who[o]]) m_ptr[o] = (who[o] + 1) % N;
               else begin m_lock[o] = 1; m_owner[o] = who[o]; end
            end
         end else if (xf[o]) begin
            m_stall[o] = 0;
            if (req_tail[m_owner[o]]) begin m_lock[o] = 0; m_ptr[o] = (m_owner[o] + 1) % N; end
         end else begin
`ifdef SA_LOCK_WDOG_EN
            m_stall[o]++;
            if (m_stall[o] == WDOG) begin
               m_lock[o] = 0; m_ptr[o] = (m_owner[o] + 1) % N; m_stall[o] = 0; en = 1;
            end
`endif
         end
         m_err[o] = en;
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Sample at the falling edge and compare every output with the model
   task automatic sample();
      logic [N*PW-1:0] mask;
      @(negedge clk);
      model_eval();
      mask = '0;
      for (int o = 0; o < N; o++)
         if (!rst || e_ov[o] || e_lock[o]) mask[o*PW +: PW] = '1;
      chk("rd_en",    32'(rd_en),    32'(e_rd));
      chk("out_vld",  32'(out_vld),  32'(e_ov));
      chk("lock",     32'(lock),     32'(e_lock));
      chk("wdog_err", 32'(wdog_err), 32'(e_err));
      chk("sel",      32'(sel & mask), 32'(e_sel & mask));
   endtask

   task automatic advance();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_in(logic [N-1:0] v, logic [N*PW-1:0] p, logic [N-1:0] t, logic [N-1:0] r);
      req_vld = v; req_port = p; req_tail = t; out_rdy = r;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      set_in('0, pp(7, 7, 7, 7, 7, 7, 7), '0, '1);
      sample();
      chk("reset lock", 32'(lock), 32'd0);
      advance();
      advance();
      rst = 1'b1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [N-1:0]    vld;
      logic [N*PW-1:0] port;
      logic [N-1:0]    tail;
      logic [N-1:0]    rdy;
      logic [N-1:0]    x_rd;
      logic [N-1:0]    x_ov;
      logic [N-1:0]    x_lock;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int sent, errs;
      logic [N-1:0] bp_rdy [11];

      // Fairness W, N, PE -> E from ptr=0, then ready-low, parallel, ignored
      tbl[0] = '{7'b0010110, pp(7, 0, 0, 7, 0, 7, 7), 7'h7F, 7'h7F, 7'b0000010, 7'b0000001, 7'b0};
      tbl[1] = '{7'b0010110, pp(7, 0, 0, 7, 0, 7, 7), 7'h7F, 7'h7F, 7'b0000100, 7'b0000001, 7'b0};
      tbl[2] = '{7'b0010110, pp(7, 0, 0, 7, 0, 7, 7), 7'h7F, 7'h7F, 7'b0010000, 7'b0000001, 7'b0};
      tbl[3] = '{7'b0010110, pp(7, 0, 0, 7, 0, 7, 7), 7'h7F, 7'h7F, 7'b0000010, 7'b0000001, 7'b0};
      tbl[4] = '{7'b0000010, pp(7, 0, 7, 7, 7, 7, 7), 7'h7F, 7'b1111110, 7'b0, 7'b0, 7'b0};
      tbl[5] = '{7'b0011111, pp(1, 0, 3, 3, 5, 7, 7), 7'h7F, 7'h7F, 7'b0010111, 7'b0101011, 7'b0};
      tbl[6] = '{7'h7F, pp(7, 7, 7, 7, 7, 7, 7), 7'h7F, 7'h7F, 7'b0, 7'b0, 7'b0};
      tbl[7] = '{7'b0000001, pp(0, 7, 7, 7, 7, 7, 7), 7'h7F, 7'h7F, 7'b0, 7'b0, 7'b0};

      model_reset();
      do_reset();
      for (int t = 0; t < 8; t++) begin
         set_in(tbl[t].vld, tbl[t].port, tbl[t].tail, tbl[t].rdy);
         sample();
         chk($sformatf("tbl%0d rd_en", t),   32'(rd_en),   32'(tbl[t].x_rd));
         chk($sformatf("tbl%0d out_vld", t), 32'(out_vld), 32'(tbl[t].x_ov));
         chk($sformatf("tbl%0d lock", t),    32'(lock),    32'(tbl[t].x_lock));
         advance();
      end

      // Lock hold: 4-flit W packet to E, N waits behind it
      do_reset();
      for (int c = 0; c < 4; c++) begin
         set_in(7'b0000110, pp(7, 0, 0, 7, 7, 7, 7), {4'b0, 1'b1, (c == 3), 1'b0}, '1);
         sample();
         chk("hold sel", 32'(sel[2:0]), 32'd1);
         chk("hold rd_en", 32'(rd_en), 32'b0000010);
         chk("hold lock", 32'(lock[0]), 32'(c > 0));
         advance();
      end
      set_in(7'b0000100, pp(7, 7, 0, 7, 7, 7, 7), 7'h7F, '1);
      sample();
      chk("hold next", 32'(rd_en), 32'b0000100);
      chk("hold unlock", 32'(lock[0]), 32'd0);
      advance();

      // Backpressure: a 6-flit W packet to E stalls 5 cycles mid-packet
      do_reset();
      bp_rdy = '{7'h7F, 7'h7F, 7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      sent = 0;
      for (int c = 0; c < 11; c++) begin
         set_in(7'b0000110, pp(7, 0, 0, 7, 7, 7, 7), {4'b0, 1'b1, (sent == 5), 1'b0}, bp_rdy[c]);
         sample();
         if (!bp_rdy[c][0]) begin
            chk("bp out_vld", 32'(out_vld[0]), 32'd0);
            chk("bp rd_en W", 32'(rd_en[1]), 32'd0);
            chk("bp owner", 32'(sel[2:0]), 32'd1);
            chk("bp lock", 32'(lock[0]), 32'd1);
         end else begin
            chk("bp rd_en W", 32'(rd_en[1]), 32'd1);
         end
         if (rd_en[1]) sent++;
         advance();
      end
      chk("bp flits", 32'(sent), 32'd6);
      set_in(7'b0000100, pp(7, 7, 0, 7, 7, 7, 7), 7'h7F, '1);
      sample();
      chk("bp after", 32'(rd_en), 32'b0000100);
      advance();

      // Watchdog: owner goes silent while holding E
      do_reset();
      set_in(7'b0000010, pp(7, 0, 7, 7, 7, 7, 7), 7'b0, '1);
      sample();
      advance();
      errs = 0;
      for (int c = 0; c < WDOG + 5; c++) begin
         set_in(7'b0, pp(7, 0, 7, 7, 7, 7, 7), 7'b0, '1);
         sample();
         errs += int'(wdog_err[0]);
         advance();
      end
      sample();
`ifdef SA_LOCK_WDOG_EN
      chk("wdog pulses", 32'(errs), 32'd1);
      chk("wdog lock", 32'(lock[0]), 32'd0);
`else
      chk("wdog pulses", 32'(errs), 32'd0);
      chk("wdog lock", 32'(lock[0]), 32'd1);
`endif
      advance();

      // Reset mid-packet: outputs clear at once, pointer restarts from 0
      do_reset();
      set_in(7'b0000010, pp(7, 0, 7, 7, 7, 7, 7), 7'h7F, '1);
      sample();
      advance();
      set_in(7'b0000100, pp(7, 7, 0, 7, 7, 7, 7), 7'b0, '1);
      sample();
      advance();
      rst = 1'b0;
      set_in(7'b0000110, pp(7, 0, 0, 7, 7, 7, 7), 7'b0, '1);
      sample();
      chk("rst rd_en", 32'(rd_en), 32'd0);
      chk("rst out_vld", 32'(out_vld), 32'd0);
      chk("rst lock", 32'(lock), 32'd0);
      chk("rst sel", 32'(sel), 32'd0);
      advance();
      rst = 1'b1;
      set_in(7'b0000110, pp(7, 0, 0, 7, 7, 7, 7), 7'h7F, '1);
      sample();
      chk("rst first grant", 32'(rd_en), 32'b0000010);
      advance();

      // Random traffic against the model
      do_reset();
      for (int c = 0; c < 400; c++) begin
         logic [N*PW-1:0] p;
         p = '0;
         for (int i = 0; i < N; i++) p[i*PW +: PW] = PW'($urandom_range(0, 7));
         set_in(N'($urandom), p, N'($urandom & $urandom), N'($urandom | $urandom));
         sample();
         advance();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
